// File: rtl/wb_sram_arbiter_pkg.sv
// Shared encodings for the Wishbone/user SRAM arbiter.
// FSM state codes and access-owner codes.
package wb_sram_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic OWN_WB  = 1'b0;
  localparam logic OWN_USR = 1'b1;

  localparam int REQ_WB  = 0;
  localparam int REQ_USR = 1;

endpackage

// File: rtl/wb_sram_arbiter_rr_arb2.sv
// Two-way round-robin picker with a registered last-grant pointer.
// Index 0 is the Wishbone port, index 1 the user port.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  import wb_sram_arbiter_pkg::*;

  logic last_q;
  logic last_d;

  always_comb begin
    gnt    = req;
    last_d = last_q;
    // on contention the port not granted last wins
    if (req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end
    if (advance && (gnt != 2'b00)) begin
      last_d = gnt[REQ_USR];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/wb_sram_arbiter.sv
// Shares one single-port SRAM between the Wishbone slave port
// and a user-logic port with round-robin arbitration.
module wb_sram_arbiter #(
  parameter int          ADDR_W    = 8,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          READ_LAT  = 1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [DATA_W/8-1:0] wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [DATA_W-1:0]   wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [DATA_W-1:0]   wbs_dat_o,
  input  logic                usr_req_i,
  input  logic                usr_we_i,
  input  logic [DATA_W/8-1:0] usr_sel_i,
  input  logic [ADDR_W-1:0]   usr_adr_i,
  input  logic [DATA_W-1:0]   usr_wdata_i,
  output logic                usr_gnt_o,
  output logic                usr_rvalid_o,
  output logic [DATA_W-1:0]   usr_rdata_o,
  output logic                sram_csb_o,
  output logic                sram_web_o,
  output logic [DATA_W/8-1:0] sram_wmask_o,
  output logic [ADDR_W-1:0]   sram_addr_o,
  output logic [DATA_W-1:0]   sram_din_o,
  input  logic [DATA_W-1:0]   sram_dout_i
);
  import wb_sram_arbiter_pkg::*;

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = $clog2(READ_LAT + 1);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              csb_q, csb_d;
  logic              web_q, web_d;
  logic [SEL_W-1:0]  wmask_q, wmask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] wb_dat_q, wb_dat_d;
  logic [DATA_W-1:0] usr_rdata_q, usr_rdata_d;
  logic              ack_q, ack_d;
  logic              gnt_q, gnt_d;
  logic              rvalid_q, rvalid_d;

  logic       wb_hit;
  logic       advance;
  logic       sel_we;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       unused_adr_lsb;

  assign wb_hit = wbs_cyc_i & wbs_stb_i &
    (wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign unused_adr_lsb = ^wbs_adr_i[1:0];

  assign req     = {usr_req_i, wb_hit};
  assign advance = (state_q == ST_IDLE);

  rr_arb2 u_arb (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .req     (req),
    .advance (advance),
    .gnt     (gnt)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    csb_d       = csb_q;
    web_d       = web_q;
    wmask_d     = wmask_q;
    addr_d      = addr_q;
    din_d       = din_q;
    wb_dat_d    = wb_dat_q;
    usr_rdata_d = usr_rdata_q;
    ack_d       = 1'b0;
    gnt_d       = 1'b0;
    rvalid_d    = 1'b0;
    sel_we      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          sel_we  = gnt[REQ_USR] ? usr_we_i : wbs_we_i;
          owner_d = gnt[REQ_USR] ? OWN_USR : OWN_WB;
          we_d    = sel_we;
          csb_d   = 1'b0;
          web_d   = ~sel_we;
          if (gnt[REQ_USR]) begin
            wmask_d = sel_we ? usr_sel_i : '0;
            addr_d  = usr_adr_i;
            din_d   = usr_wdata_i;
          end else begin
            wmask_d = sel_we ? wbs_sel_i : '0;
            addr_d  = wbs_adr_i[ADDR_W+1:2];
            din_d   = wbs_dat_i;
          end
          gnt_d   = gnt[REQ_USR];
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        csb_d = 1'b1;
        web_d = 1'b1;
        if (we_q) begin
          ack_d   = (owner_q == OWN_WB);
          state_d = ST_RESP;
        end else begin
          cnt_d   = CNT_W'(READ_LAT);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          if (owner_q == OWN_WB) begin
            wb_dat_d = sram_dout_i;
            ack_d    = 1'b1;
          end else begin
            usr_rdata_d = sram_dout_i;
            rvalid_d    = 1'b1;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_WB;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      csb_q       <= 1'b1;
      web_q       <= 1'b1;
      wmask_q     <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      wb_dat_q    <= '0;
      usr_rdata_q <= '0;
      ack_q       <= 1'b0;
      gnt_q       <= 1'b0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      csb_q       <= csb_d;
      web_q       <= web_d;
      wmask_q     <= wmask_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      wb_dat_q    <= wb_dat_d;
      usr_rdata_q <= usr_rdata_d;
      ack_q       <= ack_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
    end
  end

  // an aborted WB cycle still completes internally but sees no ack
  assign wbs_ack_o    = ack_q & wbs_cyc_i;
  assign wbs_dat_o    = wb_dat_q;
  assign usr_gnt_o    = gnt_q;
  assign usr_rvalid_o = rvalid_q;
  assign usr_rdata_o  = usr_rdata_q;
  assign sram_csb_o   = csb_q;
  assign sram_web_o   = web_q;
  assign sram_wmask_o = wmask_q;
  assign sram_addr_o  = addr_q;
  assign sram_din_o   = din_q;

endmodule
